prog_loader: RTL

- Byte-stream program loader that sits directly upstream of the CPU's instruction memory (`fetch_module.memory`).
- Receives framed bytes, assembles them into 16-bit big-endian instruction words and writes them to consecutive instruction-memory addresses.
- Holds the CPU in reset until a complete, valid frame has been written.
- Replaces testbench back-door preloading with a path usable on the board.

---
 rtl/prog_loader_if.sv | 30 +++
 rtl/prog_loader.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write bus of the program loader.
// master = loader side, slave = byte source / instruction-memory side.
interface prog_loader_if #(
   parameter int ADDR_W = 8
);
   logic [7:0]        in_data;
   logic              in_valid;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_wdata;

   modport master (
      input  in_data,
      input  in_valid,
      output in_ready,
      output mem_we,
      output mem_addr,
      output mem_wdata
   );

   modport slave (
      output in_data,
      output in_valid,
      input  in_ready,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata
   );
endinterface

// File: rtl/prog_loader.sv
// Framed byte-stream loader: assembles big-endian 16-bit words into instruction memory
// and holds the CPU in reset until a full frame is written. Optional checksum: LOADER_CSUM_EN.
//
// state | meaning
// IDLE  | hunting for HDR_BYTE, other bytes discarded
// LEN   | waiting for length byte L
// HI    | waiting for high byte of next word
// LO    | waiting for low byte of next word
// WR    | one-cycle memory write, input stalled
// CSUM  | waiting for checksum byte (LOADER_CSUM_EN only)
// DONE  | frame accepted, CPU released, behaves as IDLE for the incoming byte
module prog_loader #(
   parameter int         ADDR_W    = 8,
   parameter int         BASE_ADDR = 0,
   parameter logic [7:0] HDR_BYTE  = 8'hA5
) (
   input  logic            CLK,
   input  logic            rst,
   prog_loader_if.master   bus,
   output logic            cpu_hold,
   output logic            load_done,
   output logic            load_err
);

   localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
   localparam int                N_MAX_I = (ADDR_W >= 8) ? 256 : (1 << ADDR_W);
   localparam logic [8:0]        N_MAX   = 9'(N_MAX_I);

   typedef enum logic [2:0] {
      IDLE,
      LEN,
      HI,
      LO,
      WR,
`ifdef LOADER_CSUM_EN
      CSUM,
`endif
      DONE
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              ready;
   logic              accept;
   logic              last_word;
   logic [8:0]        cnt;
   logic [ADDR_W-1:0] addr;
   logic [7:0]        hi_byte;
   logic [ADDR_W-1:0] wr_addr;
   logic [15:0]       wr_data;
   logic              hold_q;
   logic              done_q;
`ifdef LOADER_CSUM_EN
   logic [7:0]        xsum;
   logic              err_q;
`endif

   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ready     = (state != WR);
      accept    = bus.in_valid && ready;
      last_word = (cnt == 9'd1);
      case (state)
         IDLE, DONE: begin
            if (accept && (bus.in_data == HDR_BYTE)) state_nxt = LEN;
            else                                     state_nxt = IDLE;
         end
         LEN: if (accept) state_nxt = HI;
         HI:  if (accept) state_nxt = LO;
         LO:  if (accept) state_nxt = WR;
         WR: begin
            if (!last_word) state_nxt = HI;
            else begin
`ifdef LOADER_CSUM_EN
               state_nxt = CSUM;
`else
               state_nxt = DONE;
`endif
            end
         end
`ifdef LOADER_CSUM_EN
         CSUM: begin
            if (accept) state_nxt = (bus.in_data == xsum) ? DONE : IDLE;
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   // wr_addr/wr_data are captured only when a complete word is in hand, so the
   // memory bus holds the last written word while the running address moves on.
   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         cnt     <= '0;
         addr    <= BASE;
         hi_byte <= '0;
         wr_addr <= BASE;
         wr_data <= '0;
         hold_q  <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (accept && (bus.in_data == HDR_BYTE)) begin
                  hold_q <= 1'b1;
                  done_q <= 1'b0;
               end
            end
            LEN: begin
               if (accept) begin
                  cnt  <= (bus.in_data == 8'd0) ? N_MAX : {1'b0, bus.in_data};
                  addr <= BASE;
               end
            end
            HI: begin
               if (accept) hi_byte <= bus.in_data;
            end
            LO: begin
               if (accept) begin
                  wr_addr <= addr;
                  wr_data <= {hi_byte, bus.in_data};
               end
            end
            WR: begin
               addr <= addr + 1'b1;
               cnt  <= cnt - 9'd1;
`ifndef LOADER_CSUM_EN
               if (last_word) begin
                  hold_q <= 1'b0;
                  done_q <= 1'b1;
               end
`endif
            end
`ifdef LOADER_CSUM_EN
            CSUM: begin
               if (accept && (bus.in_data == xsum)) begin
                  hold_q <= 1'b0;
                  done_q <= 1'b1;
               end
            end
`endif
            default: ;
         endcase
      end
   end

`ifdef LOADER_CSUM_EN
   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         xsum  <= '0;
         err_q <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: if (accept && (bus.in_data == HDR_BYTE)) err_q <= 1'b0;
            LEN:        if (accept) xsum <= '0;
            HI, LO:     if (accept) xsum <= xsum ^ bus.in_data;
            CSUM:       if (accept && (bus.in_data != xsum)) err_q <= 1'b1;
            default: ;
         endcase
      end
   end

   assign load_err = err_q;
`else
   assign load_err = 1'b0;
`endif

   assign bus.in_ready  = ready;
   assign bus.mem_we    = (state == WR);
   assign bus.mem_addr  = wr_addr;
   assign bus.mem_wdata = wr_data;
   assign cpu_hold      = hold_q;
   assign load_done     = done_q;

endmodule
